line_stepper: RTL
=================

LINE_STEPPER -- requirements
Module: line_stepper

Interface
REQ-001 Parameter W, default 3, SHALL set the coordinate width in bits (8x8 grid at default).
REQ-002 clk  input  1  SHALL be the rising-edge clock for all state.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 init  input  1  SHALL be a one-cycle load/start strobe from the upstream init stage.
REQ-005 swapxy  input  1  SHALL mark that the start/end coordinates arrive axis-swapped (steep line); sampled on init.
REQ-006 x, y  input  W each  SHALL be the start point (swapped space), sampled on init.
REQ-007 xend, yend  input  W each  SHALL be the end point (swapped space), sampled on init.
REQ-008 out_ready  input  1  SHALL be the downstream ready (pixel accepted when out_valid && out_ready).
REQ-009 px, py  output  W each  SHALL be the current pixel in screen space.
REQ-010 out_valid  output  1  SHALL flag a valid pixel on px/py.
REQ-011 busy  output  1  SHALL be high while a line is in progress (state RUN).
REQ-012 done  output  1  SHALL pulse for one cycle after the final pixel handshake.

Function
REQ-013 States SHALL be IDLE and RUN only; out_valid = busy = (state == RUN).
REQ-014 On init in any state, the block SHALL latch start/end/swapxy, set cx=x, cy=y, dx=|xend-x|, dy=|yend-y|, xstep=+1 if xend>=x else -1, ystep=+1 if yend>=y else -1, err=2*dy-dx, and enter RUN next cycle.
REQ-015 err SHALL be a signed W+3-bit register; dx, dy SHALL be unsigned W-bit; no overflow occurs for any W-bit input.
REQ-016 Latency: with init at edge k, out_valid SHALL be high from edge k+1 presenting the start point.
REQ-017 px/py SHALL be (cx,cy) when latched swapxy=0 and (cy,cx) when swapxy=1.
REQ-018 px/py SHALL hold stable while out_valid && !out_ready.
REQ-019 On handshake with cx==xend latched, the block SHALL return to IDLE and assert done for exactly the next cycle.
REQ-020 On handshake with cx!=xend: if err>0, cy+=ystep and err+=2*(dy-dx); else err+=2*dy; in both cases cx+=xstep.
REQ-021 Coordinates SHALL wrap modulo 2^W; upstream guarantees dy<=dx, but any input SHALL still terminate since cx moves monotonically to xend.
REQ-022 init coinciding with a handshake SHALL take priority: the handshake pixel counts as consumed, no done pulse, new line loads.
REQ-023 init during RUN SHALL abort the current line (no done) and restart with the new operands.
REQ-024 In IDLE, px/py SHALL hold the last pixel emitted (zero after reset); out_ready SHALL be ignored.
REQ-025 A degenerate line (start==end) SHALL emit exactly one pixel then done.

Reset
REQ-026 reset_n low SHALL immediately force state IDLE, out_valid=0, busy=0, done=0, px=py=0, cx=cy=0, err=0, and clear latched operands/swapxy.
REQ-027 Reset asserted mid-line SHALL discard the line; after release, no output activity SHALL occur until the next init.
REQ-028 init coincident with the first clock edge after reset_n release SHALL be honoured normally.

Verification
REQ-029 init, swapxy=0, (x,y)=(0,0), (xend,yend)=(3,1), out_ready=1 -> pixels (0,0),(1,0),(2,1),(3,1) on 4 consecutive cycles, then done one cycle, busy low.
REQ-030 Same operands with swapxy=1 -> pixels (0,0),(0,1),(1,2),(1,3), then done.
REQ-031 (x,y)=(7,7), (xend,yend)=(4,7), swapxy=0 -> pixels (7,7),(6,7),(5,7),(4,7); checks negative xstep.
REQ-032 (x,y)=(2,5)=(xend,yend) -> single pixel (2,5), done next cycle.
REQ-033 Line of REQ-029 with out_ready toggled 1,0,0,1,1,0,1 -> same 4-pixel sequence; px/py stable during every stall; total cycles = 4 accepts + 3 stalls.
REQ-034 reset_n pulsed low after second pixel of REQ-029 -> outputs zero asynchronously, no done; new init with (1,1)->(2,2) -> pixels (1,1),(2,2), done.

Source files
------------

// File: rtl/line_stepper.sv
// line_stepper: Bresenham line walker with a valid/ready pixel output.
// Coordinates arrive in "swapped" space (the major axis is always x) and are
// mapped back to screen space on the output according to the latched swapxy.
module line_stepper #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         swapxy,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] xend,
    input  logic [W-1:0] yend,
    input  logic         out_ready,
    output logic [W-1:0] px,
    output logic [W-1:0] py,
    output logic         out_valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Error term is three bits wider than a coordinate so 2*dy - dx and the
    // per-step increments never overflow for any W-bit operand.
    localparam int EW = W + 3;
    localparam logic [W-1:0]         ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] ERR_ZERO = {EW{1'b0}};

    // |a - b| as an unsigned W-bit quantity
    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

    // zero-extend an unsigned coordinate delta into the signed error width
    function automatic logic signed [EW-1:0] ext(input logic [W-1:0] v);
        return $signed({3'b000, v});
    endfunction

    // multiply a signed error-width value by two
    function automatic logic signed [EW-1:0] twice(input logic signed [EW-1:0] v);
        return $signed({v[EW-2:0], 1'b0});
    endfunction

    state_t                state_r, state_s;
    logic [W-1:0]          cx_r, cx_s;
    logic [W-1:0]          cy_r, cy_s;
    logic [W-1:0]          xend_r, xend_s;
    logic                  swap_r, swap_s;
    logic [W-1:0]          dx_r, dx_s;
    logic [W-1:0]          dy_r, dy_s;
    logic                  xneg_r, xneg_s;
    logic                  yneg_r, yneg_s;
    logic signed [EW-1:0]  err_r, err_s;
    logic [W-1:0]          px_r, px_s;
    logic [W-1:0]          py_r, py_s;
    logic                  done_r, done_s;

    // Next-state logic: init load has priority over stepping; the y end point
    // is only needed through dy/ystep, so it is not kept as its own register.
    always_comb begin
        state_s = state_r;
        cx_s    = cx_r;
        cy_s    = cy_r;
        xend_s  = xend_r;
        swap_s  = swap_r;
        dx_s    = dx_r;
        dy_s    = dy_r;
        xneg_s  = xneg_r;
        yneg_s  = yneg_r;
        err_s   = err_r;
        done_s  = 1'b0;

        if (init) begin
            state_s = RUN;
            cx_s    = x;
            cy_s    = y;
            xend_s  = xend;
            swap_s  = swapxy;
            dx_s    = abs_diff(xend, x);
            dy_s    = abs_diff(yend, y);
            xneg_s  = (xend < x);
            yneg_s  = (yend < y);
            err_s   = twice(ext(abs_diff(yend, y))) - ext(abs_diff(xend, x));
        end else if (state_r == RUN) begin
            if (out_ready) begin
                if (cx_r == xend_r) begin
                    // final pixel consumed
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    cx_s = xneg_r ? (cx_r - ONE) : (cx_r + ONE);
                    if (err_r > ERR_ZERO) begin
                        cy_s  = yneg_r ? (cy_r - ONE) : (cy_r + ONE);
                        err_s = err_r + twice(ext(dy_r) - ext(dx_r));
                    end else begin
                        err_s = err_r + twice(ext(dy_r));
                    end
                end
            end else begin
                // stalled: everything holds
                state_s = RUN;
            end
        end else begin
            // idle: hold the last pixel, ignore out_ready
            state_s = IDLE;
        end

        // screen-space mapping of the next current pixel
        if (swap_s) begin
            px_s = cy_s;
            py_s = cx_s;
        end else begin
            px_s = cx_s;
            py_s = cy_s;
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cx_r    <= {W{1'b0}};
            cy_r    <= {W{1'b0}};
            xend_r  <= {W{1'b0}};
            swap_r  <= 1'b0;
            dx_r    <= {W{1'b0}};
            dy_r    <= {W{1'b0}};
            xneg_r  <= 1'b0;
            yneg_r  <= 1'b0;
            err_r   <= ERR_ZERO;
            px_r    <= {W{1'b0}};
            py_r    <= {W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cx_r    <= cx_s;
            cy_r    <= cy_s;
            xend_r  <= xend_s;
            swap_r  <= swap_s;
            dx_r    <= dx_s;
            dy_r    <= dy_s;
            xneg_r  <= xneg_s;
            yneg_r  <= yneg_s;
            err_r   <= err_s;
            px_r    <= px_s;
            py_r    <= py_s;
            done_r  <= done_s;
        end
    end

    assign px        = px_r;
    assign py        = py_r;
    assign out_valid = (state_r == RUN);
    assign busy      = (state_r == RUN);
    assign done      = done_r;

endmodule
